// File: rtl/logic_gate_unit_if.sv
// Operand/result handshake bundle for logic_gate_unit.
// master = operand producer / result consumer, slave = the unit itself.
interface logic_gate_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic             in_acc;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic             out_ones;
    logic             out_parity;
    logic             out_err;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_op, in_acc, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_y, out_zero, out_ones, out_parity,
               out_err, err_count
    );

    modport slave (
        input  in_valid, in_op, in_acc, in_a, in_b, out_ready,
        output in_ready, out_valid, out_y, out_zero, out_ones, out_parity,
               out_err, err_count
    );
endinterface

// File: rtl/logic_gate_unit.sv
// Registered WIDTH-bit bitwise gate unit with valid/ready flow control,
// accumulate mode, reduction flags and a saturating illegal-opcode counter.

// One result bit: the seven gate functions plus the illegal opcode (forces 0).
module lgu_lane (
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y
);
    // Gate select for a single bit position
    always_comb begin
        y = 1'b0;
        case (op)
            3'd0:    y = a & b;
            3'd1:    y = a | b;
            3'd2:    y = ~(a & b);
            3'd3:    y = ~(a | b);
            3'd4:    y = a ^ b;
            3'd5:    y = ~(a ^ b);
            3'd6:    y = ~a;
            default: y = 1'b0;
        endcase
    end
endmodule

module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    logic_gate_unit_if.slave bus
);
    typedef struct packed {
        logic [2:0]       op;
        logic             acc;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    localparam logic [2:0]       OP_ILLEGAL = 3'd7;
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    req_t             req;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] y_nxt;
    logic             accept;
    logic             illegal;

    assign req      = '{op: bus.in_op, acc: bus.in_acc, a: bus.in_a, b: bus.in_b};
    // A held result blocks new work unless it is being consumed this cycle.
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept   = bus.in_valid && bus.in_ready;
    assign illegal  = (req.op == OP_ILLEGAL);
    assign b_eff    = req.acc ? acc : req.b;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        lgu_lane u_lane (
            .op (req.op),
            .a  (req.a[i]),
            .b  (b_eff[i]),
            .y  (y_nxt[i])
        );
    end

    // Result/flag register: loads on accept, drops valid on a bare consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.out_y      <= '0;
            bus.out_zero   <= 1'b1;
            bus.out_ones   <= 1'b0;
            bus.out_parity <= 1'b0;
            bus.out_err    <= 1'b0;
        end else if (accept) begin
            bus.out_valid  <= 1'b1;
            bus.out_y      <= y_nxt;
            bus.out_zero   <= (y_nxt == '0);
            bus.out_ones   <= &y_nxt;
            bus.out_parity <= ^y_nxt;
            bus.out_err    <= illegal;
        end else if (bus.out_ready) begin
            bus.out_valid  <= 1'b0;
        end
    end

    // Accumulator follows legal results at accept time; counter tracks illegal ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            bus.err_count <= '0;
        end else if (accept) begin
            if (!illegal)
                acc <= y_nxt;
            else if (bus.err_count != CNT_MAX)
                bus.err_count <= bus.err_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: directed scenarios plus a random
// run, all compared against a transaction-level reference model.
module tb_logic_gate_unit;
    localparam int W  = 8;
    localparam int CW = 4;
    localparam int VW = 1 + W + 4 + CW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic_gate_unit_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    logic_gate_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit         m_valid;
    int         m_y;
    bit         m_err;
    int         m_cnt;
    int         m_acc;

    logic [VW-1:0] obs;
    assign obs = {bus.out_valid, bus.out_y, bus.out_zero, bus.out_ones,
                  bus.out_parity, bus.out_err, bus.err_count};

    function automatic int ref_gate(int op, int a, int b);
        int mask = (1 << W) - 1;
        case (op)
            0: return a & b;
            1: return a | b;
            2: return mask - (a & b);
            3: return mask - (a | b);
            4: return a ^ b;
            5: return mask - (a ^ b);
            6: return mask - a;
            default: return 0;
        endcase
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic       z, o, p;
        z = (m_y == 0);
        o = (m_y == (1 << W) - 1);
        p = ($countones(m_y) % 2) == 1;
        return {m_valid, W'(m_y), z, o, p, m_err, CW'(m_cnt)};
    endfunction

    function automatic bit exp_ready();
        return !m_valid || bus.out_ready;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_y = 0; m_err = 0; m_cnt = 0; m_acc = 0;
    endtask

    task automatic drive(bit v, int op, bit acc_sel, int a, int b, bit ordy);
        bus.in_valid  = v;
        bus.in_op     = 3'(op);
        bus.in_acc    = acc_sel;
        bus.in_a      = W'(a);
        bus.in_b      = W'(b);
        bus.out_ready = ordy;
    endtask

    // Advance one clock: model consumes the driven inputs at the edge,
    // then return at the falling edge for sampling.
    task automatic tick();
        bit rdy;
        int beff;
        int y;
        @(posedge clk);
        rdy = !m_valid || bus.out_ready;
        if (bus.in_valid && rdy) begin
            beff    = bus.in_acc ? m_acc : int'(bus.in_b);
            y       = ref_gate(int'(bus.in_op), int'(bus.in_a), beff);
            m_valid = 1;
            m_y     = y;
            m_err   = (bus.in_op == 3'd7);
            if (m_err) m_cnt = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
            else       m_acc = y;
        end else if (bus.out_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [VW-1:0] rst_vec;
        rst_vec = {1'b0, {W{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0, {CW{1'b0}}};
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== rst_vec) begin
            failures++; $display("FAIL reset_outputs got=%h exp=%h", obs, rst_vec);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_ready got=%b/%b exp=1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_ops();
        int exp_y [7] = '{'h30, 'hFC, 'hCF, 'h03, 'hCC, 'h33, 'h0F};
        for (int op = 0; op < 7; op++) begin
            drive(1, op, 0, 'hF0, 'h3C, 1);
            tick();
            checks++;
            if (bus.out_y !== W'(exp_y[op]) || bus.out_valid !== 1'b1) begin
                failures++; $display("FAIL op%0d_y got=%h exp=%h", op, bus.out_y, exp_y[op]);
            end
            checks++;
            if (obs !== exp_vec()) begin
                failures++; $display("FAIL op%0d_vec got=%h exp=%h", op, obs, exp_vec());
            end
        end
    endtask

    task automatic test_backpressure();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        drive(1, 0, 0, 'hF0, 'h3C, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 'hF0, 'h3C, 0);
            #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++; $display("FAIL bp_ready%0d got=%b exp=0", i, bus.in_ready);
            end
            tick();
            checks++;
            if (bus.out_y !== 8'h30 || bus.out_valid !== 1'b1) begin
                failures++; $display("FAIL bp_hold%0d got=%h exp=30", i, bus.out_y);
            end
        end
        drive(1, 1, 0, 'hF0, 'h3C, 1);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_y !== 8'hFC || obs !== exp_vec()) begin
            failures++; $display("FAIL bp_release got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_accumulate();
        drive(1, 0, 0, 'hFF, 'h0F, 1);
        tick();
        checks++;
        if (bus.out_y !== 8'h0F) begin
            failures++; $display("FAIL acc_a got=%h exp=0f", bus.out_y);
        end
        drive(1, 1, 1, 'hF0, 'h00, 1);
        tick();
        checks++;
        if (bus.out_y !== 8'hFF || bus.out_ones !== 1'b1 || bus.out_zero !== 1'b0) begin
            failures++; $display("FAIL acc_b got=%h/%b exp=ff/1", bus.out_y, bus.out_ones);
        end
        drive(1, 4, 1, 'hFF, 'hAA, 1);
        tick();
        checks++;
        if (bus.out_y !== 8'h00 || bus.out_zero !== 1'b1 || bus.out_parity !== 1'b0) begin
            failures++; $display("FAIL acc_c got=%h/%b/%b exp=00/1/0", bus.out_y, bus.out_zero, bus.out_parity);
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 20; i++) begin
            drive(1, 7, 0, $urandom, $urandom, 1);
            tick();
            checks++;
            if (bus.out_err !== 1'b1 || bus.out_y !== 8'h00 ||
                bus.err_count !== CW'((i + 1 > 15) ? 15 : i + 1)) begin
                failures++; $display("FAIL illegal%0d got=%b/%h/%0d exp=1/00/%0d", i,
                    bus.out_err, bus.out_y, bus.err_count, (i + 1 > 15) ? 15 : i + 1);
            end
        end
        // acc is still 00 from the accumulate test, so XOR with A gives A back.
        drive(1, 4, 1, 'h5A, 'hFF, 1);
        tick();
        checks++;
        if (bus.out_y !== 8'h5A || bus.out_err !== 1'b0 || bus.err_count !== 4'd15) begin
            failures++; $display("FAIL illegal_acc got=%h/%b/%0d exp=5a/0/15", bus.out_y, bus.out_err, bus.err_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] rst_vec;
        rst_vec = {1'b0, {W{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0, {CW{1'b0}}};
        drive(1, 2, 0, 'h12, 'h34, 0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== rst_vec) begin
            failures++; $display("FAIL reset_mid got=%h exp=%h", obs, rst_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 'hF0, 'h3C, 1);
        tick();
        checks++;
        if (bus.out_y !== 8'h30 || bus.out_valid !== 1'b1 || obs !== exp_vec()) begin
            failures++; $display("FAIL reset_mid_after got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, $urandom_range(0, 7), $urandom % 2,
                  $urandom, $urandom, ($urandom % 3) != 0);
            #1;
            checks++;
            if (bus.in_ready !== exp_ready()) begin
                failures++; $display("FAIL rnd_ready%0d got=%b exp=%b", i, bus.in_ready, exp_ready());
            end
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                failures++; $display("FAIL rnd_vec%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_ops();
        test_backpressure();
        test_accumulate();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
